lag_pl_credit_return: RTL and testbench
=======================================

LAG_PL_CREDIT_RETURN -- requirements
Module: LAG_pl_credit_return

Interface
REQ-001 Parameters SHALL be, one per line:
- num_pls, 4, number of physical lanes (PLs) sharing the link.
- buf_depth, 4, flit slots per PL; equals the upstream sender's init_credits.
- flit_width, 16, flit payload bits.
- registered_credit, 1, 1 = credit pulse one cycle after dequeue; 0 = same-cycle credit pulse.
- counter_bits, clogb2(buf_depth+1), occupancy counter width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flit_in, in, flit_width, link data; meaningful when any flits_valid bit is set.
- flits_valid, in, num_pls, one-hot write strobe for PL i.
- pl_deq, in, num_pls, consumer pops the head of PL i; multiple bits may be set.
- flit_out, out, num_pls*flit_width, head flit of each PL.
- pl_valid, out, num_pls, PL i non-empty.
- pl_occupancy, out, num_pls*counter_bits, stored flits per PL.
- channel_cntrl_out, out, num_pls, credit return pulse to the upstream sender, one pulse per freed slot.
- protocol_err, out, 1, sticky error flag.

Function
REQ-003 Each PL SHALL own an independent FIFO of buf_depth entries with read pointer, write pointer and occupancy counter.
REQ-004 Pointers SHALL wrap from buf_depth-1 to 0; buf_depth need not be a power of two.
REQ-005 A write on flits_valid[i] SHALL store flit_in at PL i's write pointer at the clock edge; flit_out[i] and pl_valid[i] SHALL reflect it the next cycle.
REQ-006 A dequeue SHALL be accepted only when pl_deq[i] && pl_valid[i]; an accepted dequeue advances the read pointer and frees one slot.
REQ-007 There SHALL be no fall-through: a write and pl_deq on an empty PL in the same cycle stores the flit, ignores the dequeue, and sets protocol_err.
REQ-008 pl_deq[i] on an empty PL SHALL be ignored and SHALL set protocol_err.
REQ-009 A simultaneous write and accepted dequeue on the same PL SHALL leave occupancy unchanged; this SHALL be legal even when the PL is full.
REQ-010 A write to a full PL without an accepted dequeue SHALL drop the flit, leave state unchanged, and set protocol_err.
REQ-011 More than one flits_valid bit set SHALL set protocol_err, and no PL SHALL be written that cycle.
REQ-012 Occupancy per PL SHALL always stay in 0..buf_depth.
REQ-013 Occupancy arithmetic SHALL be counter_bits wide with no wrap; pl_valid[i] = (occupancy != 0).
REQ-014 With registered_credit=1, channel_cntrl_out[i] SHALL pulse high for exactly one cycle, the cycle after each accepted dequeue.
REQ-015 With registered_credit=0, channel_cntrl_out[i] SHALL be combinational from the accepted dequeue.
REQ-016 Credit pulses on different PLs SHALL be independent and may occur in the same cycle.
REQ-017 Dropped or illegal operations SHALL never generate a credit.
REQ-018 Total credits returned on PL i SHALL equal total accepted dequeues on PL i.
REQ-019 protocol_err SHALL remain set until reset.

Reset
REQ-020 On rst_n low, asynchronously and regardless of clock, all pointers and occupancies SHALL be 0.
REQ-021 During reset, pl_valid, channel_cntrl_out and protocol_err SHALL be 0.
REQ-022 FIFO data storage SHALL need no reset, and flit_out SHALL be don't-care while pl_valid is 0.
REQ-023 A credit pending at reset assertion SHALL be discarded.
REQ-024 Operation SHALL resume on the first rising clk edge after rst_n rises.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Fill PL2 (buf_depth=4) with flits 0xA1..0xA4 -> pl_occupancy[2]=4; fifth write with no dequeue -> dropped, protocol_err=1.
- Fill PL0 to 4, then write and pl_deq[0] together -> occupancy stays 4, no error; flit_out[0] order preserved; one credit pulse next cycle.
- Empty PL1: write 0x55 with pl_deq[1]=1 in the same cycle -> occupancy 1, flit_out[1]=0x55 next cycle, protocol_err=1, no credit.
- pl_deq on PL0 and PL3 in the same cycle, each holding 1 flit -> channel_cntrl_out=4'b1001 for one cycle, both pl_valid drop.
- Write 6 flits and 6 dequeues through PL3 -> wrap-around preserves order; 6 credits total; occupancy returns to 0.
- Assert rst_n mid-stream with a credit pending -> all outputs 0 immediately; no credit pulse after release.

Source files
------------

// File: rtl/lag_pl_credit_return.sv
// Per-lane input FIFOs with credit return for a shared link.
// Ports: clk, rst_n; flit_in/flits_valid write strobe; pl_deq pops;
//   flit_out/pl_valid/pl_occupancy per lane; channel_cntrl_out credit
//   pulses; protocol_err sticky error flag.
module lag_pl_credit_return #(
    parameter int num_pls           = 4,
    parameter int buf_depth         = 4,
    parameter int flit_width        = 16,
    parameter bit registered_credit = 1'b1,
    parameter int counter_bits      = $clog2(buf_depth + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [flit_width-1:0]             flit_in,
    input  logic [num_pls-1:0]                flits_valid,
    input  logic [num_pls-1:0]                pl_deq,
    output logic [num_pls*flit_width-1:0]     flit_out,
    output logic [num_pls-1:0]                pl_valid,
    output logic [num_pls*counter_bits-1:0]   pl_occupancy,
    output logic [num_pls-1:0]                channel_cntrl_out,
    output logic                              protocol_err
);

    localparam int pw = (buf_depth > 1) ? $clog2(buf_depth) : 1;

    logic [flit_width-1:0]   mem [num_pls][buf_depth];
    logic [pw-1:0]           rd_ptr [num_pls];
    logic [pw-1:0]           wr_ptr [num_pls];
    logic [counter_bits-1:0] occ [num_pls];

    logic [num_pls-1:0] wr;
    logic [num_pls-1:0] full;
    logic [num_pls-1:0] deq_ok;
    logic [num_pls-1:0] wr_ok;
    logic               multi_wr;
    logic               err_now;
    logic               err_q;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [pw-1:0] inc(input logic [pw-1:0] p);
        return (p == pw'(buf_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign multi_wr = ($countones(flits_valid) > 1);
    assign wr       = multi_wr ? '0 : flits_valid;

    always_comb begin
        pl_valid     = '0;
        full         = '0;
        flit_out     = '0;
        pl_occupancy = '0;
        for (int i = 0; i < num_pls; i++) begin
            pl_valid[i] = (occ[i] != '0);
            full[i]     = (occ[i] == counter_bits'(buf_depth));
            flit_out[i*flit_width +: flit_width]       = mem[i][rd_ptr[i]];
            pl_occupancy[i*counter_bits +: counter_bits] = occ[i];
        end
    end

    // No fall-through: a dequeue only counts against a stored flit.
    assign deq_ok = pl_deq & pl_valid;
    // A full lane still accepts a write when its head leaves this cycle.
    assign wr_ok  = wr & (~full | deq_ok);

    assign err_now = multi_wr
                   | (|(pl_deq & ~pl_valid))
                   | (|(wr & full & ~deq_ok));

    always_ff @(posedge clk) begin
        for (int i = 0; i < num_pls; i++) begin
            if (wr_ok[i]) begin
                mem[i][wr_ptr[i]] <= flit_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_pls; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                occ[i]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < num_pls; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= inc(wr_ptr[i]);
                end
                if (deq_ok[i]) begin
                    rd_ptr[i] <= inc(rd_ptr[i]);
                end
                unique case ({wr_ok[i], deq_ok[i]})
                    2'b10:   occ[i] <= occ[i] + counter_bits'(1);
                    2'b01:   occ[i] <= occ[i] - counter_bits'(1);
                    default: occ[i] <= occ[i];
                endcase
            end
            err_q <= err_q | err_now;
        end
    end

    assign protocol_err = err_q;

    generate
        if (registered_credit) begin : g_reg_credit
            logic [num_pls-1:0] cr_q;
            // Reset drops any credit still waiting to be sent.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cr_q <= '0;
                end else begin
                    cr_q <= deq_ok;
                end
            end
            assign channel_cntrl_out = cr_q;
        end else begin : g_comb_credit
            assign channel_cntrl_out = deq_ok;
        end
    endgenerate

endmodule

// File: tb/tb_lag_pl_credit_return.sv
// Directed bench for lag_pl_credit_return with a queue-based lane model.
// Checks every cycle against the model plus literal scenario expectations.
module tb_lag_pl_credit_return;

    localparam int NP = 4;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int CB = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    flit_in;
    logic [NP-1:0]   flits_valid;
    logic [NP-1:0]   pl_deq;
    logic [NP*W-1:0] flit_out;
    logic [NP-1:0]   pl_valid;
    logic [NP*CB-1:0] pl_occupancy;
    logic [NP-1:0]   channel_cntrl_out;
    logic            protocol_err;

    lag_pl_credit_return #(
        .num_pls(NP), .buf_depth(D), .flit_width(W),
        .registered_credit(1'b1), .counter_bits(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flit_in(flit_in),
        .flits_valid(flits_valid), .pl_deq(pl_deq),
        .flit_out(flit_out), .pl_valid(pl_valid),
        .pl_occupancy(pl_occupancy),
        .channel_cntrl_out(channel_cntrl_out),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  q [NP][$];
    logic          m_err;
    logic [NP-1:0] m_cred;
    int            deq_cnt [NP];
    int            cred_cnt [NP];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int occ_of(input int i);
        return int'(pl_occupancy[i*CB +: CB]);
    endfunction

    function automatic int head_of(input int i);
        return int'(flit_out[i*W +: W]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NP; i++) begin
            q[i].delete();
            deq_cnt[i]  = 0;
            cred_cnt[i] = 0;
        end
        m_err  = 1'b0;
        m_cred = '0;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("occ%0d", i), occ_of(i), q[i].size());
            chk($sformatf("valid%0d", i), int'(pl_valid[i]),
                (q[i].size() != 0) ? 1 : 0);
            if (q[i].size() != 0)
                chk($sformatf("head%0d", i), head_of(i), int'(q[i][0]));
            if (channel_cntrl_out[i]) cred_cnt[i]++;
        end
        chk("credit", int'(channel_cntrl_out), int'(m_cred));
        chk("err", int'(protocol_err), int'(m_err));
    endtask

    task automatic cycle(input logic [NP-1:0] v, input logic [W-1:0] f,
                         input logic [NP-1:0] d);
        logic [NP-1:0] acc;
        logic          multi;
        flits_valid = v;
        flit_in     = f;
        pl_deq      = d;
        @(posedge clk);
        multi = ($countones(v) > 1);
        if (multi) m_err = 1'b1;
        for (int i = 0; i < NP; i++) begin
            acc[i] = d[i] && (q[i].size() > 0);
            if (d[i] && !acc[i]) m_err = 1'b1;
            if (acc[i]) begin
                void'(q[i].pop_front());
                deq_cnt[i]++;
            end
            if (v[i] && !multi) begin
                if (q[i].size() == D) m_err = 1'b1;
                else q[i].push_back(f);
            end
        end
        m_cred = acc;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        flits_valid = '0;
        pl_deq      = '0;
        flit_in     = '0;
        model_clear();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        flits_valid = '0;
        pl_deq      = '0;
        flit_in     = '0;
        model_clear();
        #1;
        chk("rst_valid", int'(pl_valid), 0);
        chk("rst_credit", int'(channel_cntrl_out), 0);
        chk("rst_err", int'(protocol_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill PL2, then overflow
        for (int k = 0; k < 4; k++) cycle(4'b0100, W'(16'hA1 + k), 4'b0);
        chk("pl2_full_occ", occ_of(2), 4);
        chk("pl2_full_err", int'(protocol_err), 0);
        chk("pl2_head", head_of(2), 16'hA1);
        cycle(4'b0100, 16'hA5, 4'b0);
        chk("pl2_ovf_occ", occ_of(2), 4);
        chk("pl2_ovf_err", int'(protocol_err), 1);
        for (int k = 0; k < 4; k++) cycle(4'b0, 16'h0, 4'b0100);
        chk("pl2_drained", occ_of(2), 0);

        // Two write strobes at once: nothing stored
        do_reset();
        cycle(4'b0011, 16'h99, 4'b0);
        chk("multi_err", int'(protocol_err), 1);
        chk("multi_valid", int'(pl_valid), 0);

        // Full PL0: write and dequeue together
        do_reset();
        for (int k = 0; k < 4; k++) cycle(4'b0001, W'(16'h10 + k), 4'b0);
        cycle(4'b0001, 16'h14, 4'b0001);
        chk("pl0_occ", occ_of(0), 4);
        chk("pl0_err", int'(protocol_err), 0);
        chk("pl0_credit", int'(channel_cntrl_out), 4'b0001);
        chk("pl0_head", head_of(0), 16'h11);
        cycle(4'b0, 16'h0, 4'b0);
        chk("pl0_credit_once", int'(channel_cntrl_out), 0);
        for (int k = 0; k < 4; k++) cycle(4'b0, 16'h0, 4'b0001);

        // Empty PL1: write plus dequeue, no fall-through
        do_reset();
        cycle(4'b0010, 16'h55, 4'b0010);
        chk("pl1_occ", occ_of(1), 1);
        chk("pl1_head", head_of(1), 16'h55);
        chk("pl1_err", int'(protocol_err), 1);
        chk("pl1_credit", int'(channel_cntrl_out), 0);

        // Simultaneous credits on PL0 and PL3
        do_reset();
        cycle(4'b0001, 16'h77, 4'b0);
        cycle(4'b1000, 16'h88, 4'b0);
        cycle(4'b0, 16'h0, 4'b1001);
        chk("dual_credit", int'(channel_cntrl_out), 4'b1001);
        chk("dual_valid", int'(pl_valid), 0);
        cycle(4'b0, 16'h0, 4'b0);
        chk("dual_credit_end", int'(channel_cntrl_out), 0);

        // Wrap-around on PL3
        do_reset();
        for (int k = 0; k < 3; k++) cycle(4'b1000, W'(16'hC0 + k), 4'b0);
        for (int k = 3; k < 6; k++) cycle(4'b1000, W'(16'hC0 + k), 4'b1000);
        chk("wrap_head", head_of(3), 16'hC3);
        for (int k = 0; k < 3; k++) cycle(4'b0, 16'h0, 4'b1000);
        cycle(4'b0, 16'h0, 4'b0);
        chk("wrap_occ", occ_of(3), 0);
        chk("wrap_credits", cred_cnt[3], 6);
        chk("wrap_err", int'(protocol_err), 0);
        for (int i = 0; i < NP; i++)
            chk($sformatf("cred_total%0d", i), cred_cnt[i], deq_cnt[i]);

        // Reset with a credit pending
        do_reset();
        cycle(4'b0001, 16'h31, 4'b0);
        cycle(4'b0001, 16'h32, 4'b0);
        flits_valid = '0;
        pl_deq      = 4'b0001;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        pl_deq = '0;
        model_clear();
        #1;
        chk("mid_rst_credit", int'(channel_cntrl_out), 0);
        chk("mid_rst_valid", int'(pl_valid), 0);
        chk("mid_rst_occ0", occ_of(0), 0);
        chk("mid_rst_err", int'(protocol_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle(4'b0, 16'h0, 4'b0);
        chk("post_rst_credits", cred_cnt[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
